bit_stream_serializer: RTL and testbench

Parallel-to-serial front end for the bit-stream pattern recognizer. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and emits them one bit per clock on `bit_out`, which drives the recognizer's `bit_in` directly. Back-to-back words stream with no gap cycle. When no data is available, the line drives a fixed idle level, and a sticky flag records any break in a running stream.

---
 rtl/bit_stream_serializer_pkg.sv | 24 ++
 rtl/bit_stream_serializer_if.sv | 35 +++
 rtl/bit_stream_serializer_piso_shift_reg.sv | 43 ++++
 rtl/bit_stream_serializer.sv | 123 ++++++++++++
 tb/tb_bit_stream_serializer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/bit_stream_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_pkg
//  Description : Constants and types shared by the serializer front end, its
//                word source and the downstream pattern recognizer.
//                c_default_width - default word width
//                c_idle_bit      - line level when nothing is shifted
//                c_match_pattern - word the recognizer looks for
//                ser_state_t     - serializer state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package bitstream_pkg;

    localparam int         c_default_width = 8;
    localparam logic       c_idle_bit      = 1'b0;
    localparam logic [7:0] c_match_pattern = 8'hDB;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/bit_stream_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_serializer_if
//  Description : Word handshake and serial line bundle of the serializer.
//                byte_in/byte_valid/byte_ready - word input handshake
//                bit_out/bit_valid             - serial output line
//                clr_underrun/underrun         - sticky underrun flag
//                master : word source / line consumer side
//                slave  : serializer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_stream_serializer_if
    import bitstream_pkg::*;
#(
    parameter int WIDTH = c_default_width
);
    logic [WIDTH-1:0] byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             clr_underrun;
    logic             underrun;

    modport master (
        output byte_in, byte_valid, clr_underrun,
        input  byte_ready, bit_out, bit_valid, underrun
    );

    modport slave (
        input  byte_in, byte_valid, clr_underrun,
        output byte_ready, bit_out, bit_valid, underrun
    );
endinterface
`default_nettype wire

// File: rtl/bit_stream_serializer_piso_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_reg
//  Description : WIDTH-bit parallel-load / serial-out shift register.
//                clk, rstn  - clock, asynchronous active-low reset
//                i_load     - load i_din (has priority over shift)
//                i_shift    - move one place toward the output end
//                i_din      - parallel load data
//                o_dout     - bit currently at the output end
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             i_load,
    input  wire logic             i_shift,
    input  wire logic [WIDTH-1:0] i_din,
    output logic                  o_dout
);
    logic [WIDTH-1:0] r_shreg;

    generate
        if (MSB_FIRST) begin : g_msb_first
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)        r_shreg <= '0;
                else if (i_load)  r_shreg <= i_din;
                else if (i_shift) r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end
            assign o_dout = r_shreg[WIDTH-1];
        end else begin : g_lsb_first
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)        r_shreg <= '0;
                else if (i_load)  r_shreg <= i_din;
                else if (i_shift) r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
            end
            assign o_dout = r_shreg[0];
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/bit_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_serializer
//  Description : Parallel-to-serial front end. Accepts WIDTH-bit words over a
//                valid/ready handshake into a one-word hold buffer and shifts
//                them out one bit per clock, back-to-back words without a gap.
//                clk  - clock, rising edge
//                rstn - asynchronous active-low reset
//                bus  - slave side of bit_stream_serializer_if
//                       (byte_in/valid/ready, bit_out/valid, clr_underrun,
//                        underrun)
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_stream_serializer
    import bitstream_pkg::*;
#(
    parameter int   WIDTH     = c_default_width,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = c_idle_bit
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    bit_stream_serializer_if.slave bus
);
    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    ser_state_t         r_state;
    ser_state_t         w_state_nxt;
    logic               r_hold_full;
    logic               w_hold_full_nxt;
    logic [WIDTH-1:0]   r_hold_data;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [c_cnt_w-1:0] w_bit_cnt_nxt;
    logic               r_underrun;
    logic               w_underrun_nxt;
    logic               w_accept;
    logic               w_load;
    logic               w_shift;
    logic               w_last;
    logic               w_shreg_out;

    // Ready depends on the hold flag only, so the source may wait on it.
    assign w_accept = bus.byte_valid & ~r_hold_full;
    assign w_last   = (r_bit_cnt == c_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= SER_IDLE;
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_bit_cnt   <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_underrun  <= w_underrun_nxt;
            if (w_accept) begin
                r_hold_data <= bus.byte_in;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        // Clear first; a same-edge underrun below overrides it.
        w_underrun_nxt = r_underrun & ~bus.clr_underrun;

        case (r_state)
            SER_IDLE: begin
                if (r_hold_full) begin
                    w_load        = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (w_last) begin
                    if (r_hold_full) begin
                        // Reload on the last bit keeps the stream gapless.
                        w_load        = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt    = SER_IDLE;
                        w_underrun_nxt = 1'b1;
                    end
                end else begin
                    w_shift       = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = SER_IDLE;
            end
        endcase

        // Accept needs an empty hold and a drain needs a full one, so the two
        // never happen on the same edge.
        w_hold_full_nxt = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_full);
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_din   (r_hold_data),
        .o_dout  (w_shreg_out)
    );

    assign bus.byte_ready = ~r_hold_full;
    assign bus.bit_valid  = (r_state == SER_SHIFT);
    assign bus.bit_out    = (r_state == SER_SHIFT) ? w_shreg_out : IDLE_BIT;
    assign bus.underrun   = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_bit_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_stream_serializer
//  Description : Self-checking bench. Two serializers (MSB-first and
//                LSB-first) receive identical stimulus; a timeline model
//                predicts, per cycle, the line contents, ready and underrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_stream_serializer;
    import bitstream_pkg::*;

    localparam int c_w   = 8;
    localparam int c_len = 4096;

    logic           clk = 1'b0;
    logic           rstn;
    logic [c_w-1:0] din;
    logic           vld;
    logic           clr;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Timeline model: index t describes the cycle following edge t.
    logic ev   [c_len];
    logic eb_m [c_len];
    logic eb_l [c_len];
    logic est  [c_len];
    logic eend [c_len];
    int   next_free;
    int   hold_until;
    logic m_ready;
    logic m_under;

    bit_stream_serializer_if #(.WIDTH(c_w)) if_m ();
    bit_stream_serializer_if #(.WIDTH(c_w)) if_l ();

    assign if_m.byte_in      = din;
    assign if_m.byte_valid   = vld;
    assign if_m.clr_underrun = clr;
    assign if_l.byte_in      = din;
    assign if_l.byte_valid   = vld;
    assign if_l.clr_underrun = clr;

    bit_stream_serializer #(.WIDTH(c_w), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_m.slave)
    );

    bit_stream_serializer #(.WIDTH(c_w), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_l.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic v, bm, bl;
        v  = ev[cyc];
        bm = v ? eb_m[cyc] : c_idle_bit;
        bl = v ? eb_l[cyc] : c_idle_bit;
        chk("ready_m",    if_m.byte_ready, m_ready);
        chk("ready_l",    if_l.byte_ready, m_ready);
        chk("bit_valid_m", if_m.bit_valid, v);
        chk("bit_valid_l", if_l.bit_valid, v);
        chk("bit_out_m",  if_m.bit_out,    bm);
        chk("bit_out_l",  if_l.bit_out,    bl);
        chk("underrun_m", if_m.underrun,   m_under);
        chk("underrun_l", if_l.underrun,   m_under);
    endtask

    task automatic model_clear();
        for (int i = cyc; i < c_len; i++) begin
            ev[i] = 1'b0; eb_m[i] = 1'b0; eb_l[i] = 1'b0; est[i] = 1'b0; eend[i] = 1'b0;
        end
        next_free  = 0;
        hold_until = 0;
        m_ready    = 1'b1;
        m_under    = 1'b0;
    endtask

    // One clock edge: predict the accept, advance the model, check outputs.
    task automatic step();
        logic           acc;
        logic [c_w-1:0] w;
        int             s;
        acc = rstn && vld && m_ready;
        w   = din;
        @(posedge clk);
        cyc++;
        if (rstn) begin
            if (acc) begin
                s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
                for (int i = 0; i < c_w; i++) begin
                    ev[s+i]   = 1'b1;
                    eb_m[s+i] = w[c_w-1-i];
                    eb_l[s+i] = w[i];
                end
                est[s]       = 1'b1;
                eend[s+c_w]  = 1'b1;
                next_free    = s + c_w;
                hold_until   = s;
            end
            if (eend[cyc] && !est[cyc]) m_under = 1'b1;
            else if (clr)               m_under = 1'b0;
        end
        m_ready = (cyc >= hold_until);
        #1;
        chk_all();
    endtask

    task automatic send(input logic [c_w-1:0] word);
        logic a;
        logic got;
        got = 1'b0;
        din = word;
        vld = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            a = m_ready;
            step();
            if (a) got = 1'b1;
        end
        vld = 1'b0;
        chk("accept_timeout", got, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic async_reset(input int n);
        rstn = 1'b0;
        model_clear();
        #1;
        chk_all();
        repeat (n) step();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        din  = 8'h55;
        vld  = 1'b1;
        clr  = 1'b0;
        model_clear();

        // Reset held with a valid word offered: nothing may be accepted.
        idle(3);
        rstn = 1'b1;
        send(8'h55);
        idle(12);

        // Single word, then underrun; clear it.
        clr = 1'b1; step(); clr = 1'b0;
        send(c_match_pattern);
        idle(12);
        clr = 1'b1; step(); clr = 1'b0;

        // Back-to-back words with valid held.
        send(8'hA5);
        send(8'h3C);
        idle(20);
        clr = 1'b1; step(); clr = 1'b0;

        send(8'h01);
        idle(12);

        // Mid-word reset with the hold buffer also full.
        send(8'hFF);
        step();
        send(8'hFF);
        step();
        async_reset(2);
        send(8'h81);
        idle(12);

        // Clear colliding with the underrun edge: set wins.
        clr = 1'b1; step(); clr = 1'b0;
        send(8'h0F);
        while (cyc + 1 < next_free) step();
        clr = 1'b1; step(); clr = 1'b0;
        idle(3);
        clr = 1'b1; step(); clr = 1'b0;
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 700; k++) begin
            din = c_w'($urandom);
            vld = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) async_reset(1);
            else                            step();
        end
        vld = 1'b0;
        clr = 1'b0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
`default_nettype wire
